// File: rtl/vermi_timer_pkg.sv
// Shared definitions for the Vermibus timer.
//   reg_idx_t     register index decoded from address[4:2]
//   CTRL_*        bit positions inside the CTRL register
//   resp_state_t  response FSM encoding (ST_IDLE, ST_WAIT, ST_RESPOND)
//   LIMIT_RESET   value of LIMIT after reset
//   apply_strobe  byte-lane merge of a bus write into an existing value
package vermi_timer_pkg;

  typedef enum logic [2:0] {
    REG_CTRL   = 3'd0,
    REG_COUNT  = 3'd1,
    REG_LIMIT  = 3'd2,
    REG_STATUS = 3'd3,
    REG_PRESC  = 3'd4
  } reg_idx_t;

  localparam int CTRL_ENABLE      = 0;
  localparam int CTRL_IRQ_EN      = 1;
  localparam int CTRL_AUTO_RELOAD = 2;

  typedef logic [1:0] resp_state_t;
  localparam resp_state_t ST_IDLE    = 2'd0;
  localparam resp_state_t ST_WAIT    = 2'd1;
  localparam resp_state_t ST_RESPOND = 2'd2;

  localparam logic [31:0] LIMIT_RESET = 32'hFFFF_FFFF;

  // Keep each byte of old_val unless its strobe bit selects new_val.
  function automatic logic [31:0] apply_strobe(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strobe);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strobe[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/vermi_timer_if.sv
// Vermibus request/response bundle between a core (master) and a responder
// (slave).
//   valid    master -> slave  request present
//   address  master -> slave  byte address
//   wstrobe  master -> slave  byte write enables, 4'b0000 means read
//   wdata    master -> slave  write data
//   rdata    slave -> master  read data, zero whenever ready is low
//   ready    slave -> master  single-cycle response pulse
//
// Handshake: the master raises valid with address/wstrobe/wdata and holds all
// of them stable until it observes ready high. ready is a one-cycle pulse; the
// write (if any) takes effect on the clock edge that ends the ready cycle, and
// rdata is valid only during that cycle. The master drops valid (or presents
// the next request) after that edge. Responses are ORed at the interconnect,
// so a non-selected responder keeps ready and rdata at zero.
interface vermi_timer_if;
  logic        valid;
  logic [31:0] address;
  logic [3:0]  wstrobe;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;

  modport master (
    output valid, address, wstrobe, wdata,
    input  rdata, ready
  );

  modport slave (
    input  valid, address, wstrobe, wdata,
    output rdata, ready
  );
endinterface

// File: rtl/vermi_timer_counter.sv
// Counting core of the timer: optional prescaler, COUNT, compare against
// LIMIT, auto-reload and the event flag.
// Optional feature macro: VERMI_TIMER_PRESCALER_EN adds the PRESC register and
// a 16-bit prescale counter; without it a tick occurs every enabled cycle.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   enable            CTRL.enable
//   auto_reload       CTRL.auto_reload
//   limit             compare value
//   count_we          bus write to COUNT this cycle (beats the tick)
//   count_wdata       byte-merged value to load into COUNT
//   status_clr        bus write of 1 to STATUS[0]
//   ctrl_we           bus write to CTRL (prescaler build only)
//   presc_we          bus write to PRESC (prescaler build only)
//   presc_wdata       byte-merged PRESC value (prescaler build only)
//   presc             current PRESC value (prescaler build only)
//   count             current COUNT value
//   flag              event flag
//   hw_disable        pulse asking the top to clear CTRL.enable
module vermi_timer_counter
  import vermi_timer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        auto_reload,
  input  logic [31:0] limit,
  input  logic        count_we,
  input  logic [31:0] count_wdata,
  input  logic        status_clr,
`ifdef VERMI_TIMER_PRESCALER_EN
  input  logic        ctrl_we,
  input  logic        presc_we,
  input  logic [15:0] presc_wdata,
  output logic [15:0] presc,
`endif
  output logic [31:0] count,
  output logic        flag,
  output logic        hw_disable
);

  logic        tick;
  logic        step;
  logic        at_limit;
  logic [31:0] count_q;
  logic        flag_q;

`ifdef VERMI_TIMER_PRESCALER_EN
  logic [15:0] presc_q;
  logic [15:0] pcnt_q;

  assign tick  = enable && (pcnt_q == presc_q);
  assign presc = presc_q;

  // The prescale counter restarts whenever software touches CTRL or PRESC so
  // the first tick after (re)configuration is a full period away.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
      pcnt_q  <= '0;
    end else begin
      if (presc_we) begin
        presc_q <= presc_wdata;
      end
      if (presc_we || ctrl_we) begin
        pcnt_q <= '0;
      end else if (enable) begin
        pcnt_q <= tick ? 16'd0 : pcnt_q + 16'd1;
      end
    end
  end
`else
  assign tick = enable;
`endif

  // A bus write to COUNT swallows the tick of the same cycle entirely.
  assign step       = tick && !count_we;
  assign at_limit   = (count_q == limit);
  assign hw_disable = step && at_limit && !auto_reload;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else if (count_we) begin
      count_q <= count_wdata;
    end else if (step) begin
      if (at_limit) begin
        // Without auto-reload COUNT parks on LIMIT and enable is dropped.
        if (auto_reload) begin
          count_q <= '0;
        end
      end else begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  // A compare hit in the same cycle as a software clear keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flag_q <= 1'b0;
    end else if (step && at_limit) begin
      flag_q <= 1'b1;
    end else if (status_clr) begin
      flag_q <= 1'b0;
    end
  end

  assign count = count_q;
  assign flag  = flag_q;

endmodule

// File: rtl/vermi_timer.sv
// Memory-mapped timer responding on the Vermibus.
// Optional feature macro: VERMI_TIMER_PRESCALER_EN (PRESC register at 0x10).
// Parameters:
//   BASE_ADDRESS  base of the 32-byte register window, 32-byte aligned
//   WAIT_STATES   extra cycles between request accept and ready (0..15)
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   bus        Vermibus slave modport (valid/address/wstrobe/wdata/rdata/ready)
//   irq        level interrupt, flag & CTRL.irq_en
//   dbg_state  current response FSM state
// Register map (address[4:2]): 0 CTRL, 1 COUNT, 2 LIMIT, 3 STATUS, 4 PRESC,
// others read 0 and ignore writes.
module vermi_timer
  import vermi_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h8000_0000,
  parameter int unsigned WAIT_STATES  = 1
) (
  input  logic         clk,
  input  logic         reset,
  vermi_timer_if.slave bus,
  output logic         irq,
  output resp_state_t  dbg_state
);

  resp_state_t state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [31:0] rdata_q;
  logic [31:0] read_val;

  logic        hit;
  logic [2:0]  reg_sel;
  logic        wr_en;
  logic        ctrl_we;
  logic        count_we;
  logic        limit_we;
  logic        status_clr;

  logic [2:0]  ctrl_q;
  logic [31:0] limit_q;
  logic [31:0] count;
  logic        flag;
  logic        hw_disable;

  logic        unused_addr_bits;
  assign unused_addr_bits = ^bus.address[1:0];

  assign hit     = (bus.address[31:5] == BASE_ADDRESS[31:5]);
  assign reg_sel = bus.address[4:2];

  // The initiator holds the request through the ready cycle, so the write
  // is taken from the live bus on the edge that ends RESPOND.
  assign wr_en      = (state_q == ST_RESPOND) && hit && (bus.wstrobe != 4'b0000);
  assign ctrl_we    = wr_en && (reg_sel == REG_CTRL) && bus.wstrobe[0];
  assign count_we   = wr_en && (reg_sel == REG_COUNT);
  assign limit_we   = wr_en && (reg_sel == REG_LIMIT);
  assign status_clr = wr_en && (reg_sel == REG_STATUS) && bus.wstrobe[0] && bus.wdata[0];

`ifdef VERMI_TIMER_PRESCALER_EN
  logic        presc_we;
  logic [15:0] presc;
  logic [15:0] presc_wdata;

  assign presc_we    = wr_en && (reg_sel == REG_PRESC) && (bus.wstrobe[1:0] != 2'b00);
  assign presc_wdata = {bus.wstrobe[1] ? bus.wdata[15:8] : presc[15:8],
                        bus.wstrobe[0] ? bus.wdata[7:0]  : presc[7:0]};
`endif

  vermi_timer_counter u_counter (
    .clk         (clk),
    .reset       (reset),
    .enable      (ctrl_q[CTRL_ENABLE]),
    .auto_reload (ctrl_q[CTRL_AUTO_RELOAD]),
    .limit       (limit_q),
    .count_we    (count_we),
    .count_wdata (apply_strobe(count, bus.wdata, bus.wstrobe)),
    .status_clr  (status_clr),
`ifdef VERMI_TIMER_PRESCALER_EN
    .ctrl_we     (ctrl_we),
    .presc_we    (presc_we),
    .presc_wdata (presc_wdata),
    .presc       (presc),
`endif
    .count       (count),
    .flag        (flag),
    .hw_disable  (hw_disable)
  );

  // Response FSM: accept, count down the wait states, then one ready cycle.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.valid && hit) begin
          if (WAIT_STATES == 0) begin
            state_d = ST_RESPOND;
          end else begin
            state_d = ST_WAIT;
            wait_d  = WAIT_STATES[3:0];
          end
        end
      end
      ST_WAIT: begin
        wait_d = wait_q - 4'd1;
        if (wait_q == 4'd1) begin
          state_d = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    read_val = '0;
    case (reg_sel)
      REG_CTRL:   read_val = {29'b0, ctrl_q};
      REG_COUNT:  read_val = count;
      REG_LIMIT:  read_val = limit_q;
      REG_STATUS: read_val = {31'b0, flag};
`ifdef VERMI_TIMER_PRESCALER_EN
      REG_PRESC:  read_val = {16'b0, presc};
`endif
      default:    read_val = '0;
    endcase
  end

  // rdata is captured on entry to RESPOND and is zero in every other state,
  // which keeps the ORed response bus clean.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      rdata_q <= (state_d == ST_RESPOND) ? read_val : 32'd0;
    end
  end

  // A software CTRL write overrides the hardware enable clear of the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q  <= '0;
      limit_q <= LIMIT_RESET;
    end else begin
      if (ctrl_we) begin
        ctrl_q <= bus.wdata[2:0];
      end else if (hw_disable) begin
        ctrl_q[CTRL_ENABLE] <= 1'b0;
      end
      if (limit_we) begin
        limit_q <= apply_strobe(limit_q, bus.wdata, bus.wstrobe);
      end
    end
  end

  assign bus.ready = (state_q == ST_RESPOND);
  assign bus.rdata = rdata_q;
  assign irq       = flag & ctrl_q[CTRL_IRQ_EN];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_vermi_timer.sv
// Bench for vermi_timer: directed scenarios followed by random register
// traffic, all checked against a transaction-level model of the register file.
module tb_vermi_timer;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          WS   = 1;

  logic       clk;
  logic       reset;
  logic       irq;
  logic [1:0] dbg_state;

  vermi_timer_if bus_if ();

  vermi_timer #(.BASE_ADDRESS(BASE), .WAIT_STATES(WS)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_if),
    .irq       (irq),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [31:0] exp_q[$];
  logic        mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] count;
    logic [31:0] limit;
    logic        flag;
    logic [15:0] presc;
    logic [15:0] pcnt;
  } mstate_t;

  localparam mstate_t M_RESET = '{ctrl: 3'd0, count: 32'd0, limit: 32'hFFFF_FFFF,
                                  flag: 1'b0, presc: 16'd0, pcnt: 16'd0};

  mstate_t     m_s;
  logic        m_wr_en   = 1'b0;
  logic [2:0]  m_wr_idx  = 3'd0;
  logic [31:0] m_wr_data = 32'd0;
  logic [3:0]  m_wr_strb = 4'd0;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  // One clock of the timer as a function of the register file and any write.
  function automatic mstate_t model_next(input mstate_t s, input logic we, input logic [2:0] idx,
                                         input logic [31:0] d, input logic [3:0] st);
    mstate_t     n;
    logic        tick;
    logic        hw_set;
    logic [31:0] tmp;
    n      = s;
    hw_set = 1'b0;
`ifdef VERMI_TIMER_PRESCALER_EN
    tick = s.ctrl[0] && (s.pcnt == s.presc);
    if (s.ctrl[0]) n.pcnt = tick ? 16'd0 : s.pcnt + 16'd1;
`else
    tick = s.ctrl[0];
`endif
    if (tick && !(we && idx == 3'd1)) begin
      if (s.count == s.limit) begin
        hw_set = 1'b1;
        n.flag = 1'b1;
        if (s.ctrl[2]) n.count = 32'd0;
        else           n.ctrl[0] = 1'b0;
      end else begin
        n.count = s.count + 32'd1;
      end
    end
    if (we) begin
      case (idx)
        3'd0: if (st[0]) begin n.ctrl = d[2:0]; n.pcnt = 16'd0; end
        3'd1: n.count = merge(s.count, d, st);
        3'd2: n.limit = merge(s.limit, d, st);
        3'd3: if (st[0] && d[0] && !hw_set) n.flag = 1'b0;
`ifdef VERMI_TIMER_PRESCALER_EN
        3'd4: if (st[1:0] != 2'b00) begin
                tmp = merge({16'd0, s.presc}, d, st);
                n.presc = tmp[15:0];
                n.pcnt  = 16'd0;
              end
`endif
        default: ;
      endcase
    end
    return n;
  endfunction

  function automatic logic [31:0] m_read(input mstate_t s, input logic [2:0] idx);
    case (idx)
      3'd0: return {29'd0, s.ctrl};
      3'd1: return s.count;
      3'd2: return s.limit;
      3'd3: return {31'd0, s.flag};
`ifdef VERMI_TIMER_PRESCALER_EN
      3'd4: return {16'd0, s.presc};
`endif
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) m_s <= M_RESET;
    else        m_s <= model_next(m_s, m_wr_en, m_wr_idx, m_wr_data, m_wr_strb);
  end

  // Continuous checks: irq level, and rdata quiet outside the ready pulse.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("irq", {31'd0, irq}, {31'd0, m_s.flag & m_s.ctrl[1]});
      if (!bus_if.ready) chk("rdata_idle", bus_if.rdata, 32'd0);
    end
  end

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic bus_xfer(input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] data, output logic [31:0] rd);
    logic [31:0] exp_rd;
    bus_if.valid   = 1'b1;
    bus_if.address = addr;
    bus_if.wstrobe = strb;
    bus_if.wdata   = data;
    for (int k = 0; k < WS; k++) begin
      @(negedge clk);
      chk("ready_early", {31'd0, bus_if.ready}, 32'd0);
    end
    exp_q.push_back(m_read(m_s, addr[4:2]));
    @(negedge clk);
    chk("ready_latency", {31'd0, bus_if.ready}, 32'd1);
    rd     = bus_if.rdata;
    exp_rd = exp_q.pop_front();
    if (strb == 4'd0) chk("rdata", rd, exp_rd);
    m_wr_en   = (strb != 4'd0);
    m_wr_idx  = addr[4:2];
    m_wr_data = data;
    m_wr_strb = strb;
    @(negedge clk);
    m_wr_en = 1'b0;
    chk("ready_width", {31'd0, bus_if.ready}, 32'd0);
    bus_if.valid   = 1'b0;
    bus_if.wstrobe = 4'd0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] data);
    logic [31:0] rd;
    bus_xfer(BASE | {27'd0, idx, 2'd0}, 4'hF, data, rd);
  endtask

  task automatic rd_reg(input logic [2:0] idx, output logic [31:0] rd);
    bus_xfer(BASE | {27'd0, idx, 2'd0}, 4'h0, 32'd0, rd);
  endtask

  task automatic nonhit(input logic [31:0] addr, input int cycles);
    bus_if.valid   = 1'b1;
    bus_if.address = addr;
    bus_if.wstrobe = 4'hF;
    bus_if.wdata   = 32'hFFFF_FFFF;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk("nonhit_ready", {31'd0, bus_if.ready}, 32'd0);
    end
    bus_if.valid   = 1'b0;
    bus_if.wstrobe = 4'd0;
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] rd, rd2;
  int          first_hit;
  logic [2:0]  r_idx;
  logic [3:0]  r_strb;
  logic [31:0] r_data;

  initial begin
    reset          = 1'b0;
    bus_if.valid   = 1'b0;
    bus_if.address = 32'd0;
    bus_if.wstrobe = 4'd0;
    bus_if.wdata   = 32'd0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    chk("rst_ready", {31'd0, bus_if.ready}, 32'd0);
    chk("rst_rdata", bus_if.rdata, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    // LIMIT after reset, ready two cycles after the request cycle
    rd_reg(3'd2, rd);
    chk("limit_rst", rd, 32'hFFFF_FFFF);

    // auto-reload with LIMIT=3: first event four ticks after enable
    wr(3'd2, 32'd3);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd7);
    first_hit = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (irq && first_hit == 0) first_hit = k;
    end
    chk("reload_first_hit", first_hit, 32'd4);
    rd_reg(3'd1, rd);

    // one-shot: COUNT parks on LIMIT, enable drops, flag until cleared
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd5);
    wr(3'd1, 32'd0);
    wr(3'd3, 32'd1);
    wr(3'd0, 32'd3);
    repeat (12) @(negedge clk);
    rd_reg(3'd1, rd);
    chk("oneshot_count", rd, 32'd5);
    rd_reg(3'd0, rd);
    chk("oneshot_ctrl", rd, 32'd2);
    chk("oneshot_irq", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'd1);
    chk("status_clear_irq", {31'd0, irq}, 32'd0);

    // byte write to COUNT while counting
    wr(3'd0, 32'd0);
    wr(3'd2, 32'hFFFF_FFFF);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd1);
    bus_xfer(BASE | 32'h4, 4'b0001, 32'h0000_0010, rd);
    rd_reg(3'd1, rd);
    chk("count_byte_write", rd, 32'h11);

`ifdef VERMI_TIMER_PRESCALER_EN
    // PRESC=2: one tick every three cycles
    wr(3'd0, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd4, 32'd2);
    wr(3'd0, 32'd1);
    rd_reg(3'd1, rd);
    repeat (6) @(negedge clk);
    rd_reg(3'd1, rd2);
    chk("presc_rate", rd2 - rd, 32'd3);
    wr(3'd4, 32'd0);
`endif

    // STATUS clear colliding with a compare hit (LIMIT=0 hits every tick)
    wr(3'd0, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd7);
    wr(3'd3, 32'd1);
    rd_reg(3'd3, rd);
    chk("clear_vs_hit", rd, 32'd1);

    // addresses outside the window never get a response
    nonhit(32'h9000_0000, 20);
    nonhit(BASE + 32'h20, 6);
    nonhit(BASE - 32'h4, 6);

    // reset while the response is in WAIT
    chk("irq_pre_reset", {31'd0, irq}, 32'd1);
    bus_if.valid   = 1'b1;
    bus_if.address = BASE | 32'h4;
    bus_if.wstrobe = 4'd0;
    @(negedge clk);
    chk("in_wait", {30'd0, dbg_state}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_ready", {31'd0, bus_if.ready}, 32'd0);
    chk("async_rst_rdata", bus_if.rdata, 32'd0);
    chk("async_rst_irq", {31'd0, irq}, 32'd0);
    chk("async_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    bus_if.valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    rd_reg(3'd2, rd);
    chk("limit_after_rst", rd, 32'hFFFF_FFFF);

    // random register traffic against the model
    for (int t = 0; t < 300; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        nonhit(32'h9000_0000 | $urandom_range(0, 31), $urandom_range(2, 5));
      end else begin
        r_idx  = 3'($urandom_range(0, 7));
        r_strb = ($urandom_range(0, 1) == 1) ? 4'd0 : 4'($urandom_range(1, 15));
        case (r_idx)
          3'd0:       r_data = $urandom_range(0, 7);
          3'd1, 3'd2: r_data = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 24);
          3'd3:       r_data = $urandom_range(0, 1);
          3'd4:       r_data = $urandom_range(0, 3);
          default:    r_data = $urandom;
        endcase
        bus_xfer(BASE | {27'd0, r_idx, 2'd0}, r_strb, r_data, rd);
      end
    end
    for (int i = 0; i < 5; i++) rd_reg(3'(i), rd);

    @(negedge clk);
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
